mem_bus_arbiter: RTL and testbench

//   Shares one single-port memory bus between two requesters: port 0 = cpu
//   (fetch/load/store), port 1 = loader/debug (program load, memory peek/poke).

---
 rtl/mem_bus_arbiter_if.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports plus the memory-side bus, indexed [0]=cpu, [1]=loader/debug.
// The arbiter uses the slave view; requesters and memory model use the master view.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [1:0]         req;
   logic [1:0]         rw;
   logic [1:0][AW-1:0] addr;
   logic [1:0][DW-1:0] wdata;
   logic [1:0]         gnt;
   logic [1:0]         done;
   logic [1:0]         err;
   logic [1:0][DW-1:0] rdata;

   logic               mem_sel;
   logic               mem_rw;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic [DW-1:0]      mem_rdata;
   logic               mem_ready;
   logic               busy;

   modport slave (
      input  req, rw, addr, wdata, mem_rdata, mem_ready,
      output gnt, done, err, rdata, mem_sel, mem_rw, mem_addr, mem_wdata, busy
   );

   modport master (
      output req, rw, addr, wdata, mem_rdata, mem_ready,
      input  gnt, done, err, rdata, mem_sel, mem_rw, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between cpu (port 0) and
// loader/debug (port 1); one outstanding access, registered outputs, access timeout.
module mem_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   mem_bus_arbiter_if.slave    bus
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               last_q, last_d;
   logic               port_q, port_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         gnt_q, gnt_d;
   logic [1:0]         done_q, done_d;
   logic [1:0]         err_q, err_d;
   logic [1:0][DW-1:0] rdata_q, rdata_d;
   logic               mem_sel_q, mem_sel_d;
   logic               mem_rw_q, mem_rw_d;
   logic [AW-1:0]      mem_addr_q, mem_addr_d;
   logic [DW-1:0]      mem_wdata_q, mem_wdata_d;

   logic               pick;
   logic               timeout_hit;

   // On contention the port not served last wins; otherwise the lone requester.
   assign pick        = (bus.req == 2'b11) ? ~last_q : bus.req[1];
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      // NOTE: every next-state value defaults to its register so no path infers a latch.
      state_d     = state_q;
      last_d      = last_q;
      port_d      = port_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      done_d      = done_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      mem_sel_d   = mem_sel_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               port_d       = pick;
               last_d       = pick;
               mem_rw_d     = bus.rw[pick];
               mem_addr_d   = bus.addr[pick];
               mem_wdata_d  = bus.wdata[pick];
               mem_sel_d    = 1'b1;
               gnt_d        = '0;
               gnt_d[pick]  = 1'b1;
               cnt_d        = '0;
               state_d      = ACCESS;
            end
         end

         ACCESS: begin
            // Ready takes priority over a timeout landing on the same edge.
            if (bus.mem_ready) begin
               if (mem_rw_q) rdata_d[port_q] = bus.mem_rdata;
               done_d[port_q] = 1'b1;
               mem_sel_d      = 1'b0;
               gnt_d          = '0;
               state_d        = RESP;
            end else if (timeout_hit) begin
               err_d[port_q]  = 1'b1;
               mem_sel_d      = 1'b0;
               gnt_d          = '0;
               state_d        = RESP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         RESP: begin
            done_d  = '0;
            err_d   = '0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         port_q      <= 1'b0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rdata_q     <= '0;
         mem_sel_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         port_q      <= port_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_sel_q   <= mem_sel_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_sel   = mem_sel_q;
   assign bus.mem_rw    = mem_rw_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reads, writes, round-robin, timeout, async reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".gnt"},       64'(bus.gnt),       64'h0);
      check({tag, ".done"},      64'(bus.done),      64'h0);
      check({tag, ".err"},       64'(bus.err),       64'h0);
      check({tag, ".rdata0"},    64'(bus.rdata[0]),  64'h0);
      check({tag, ".rdata1"},    64'(bus.rdata[1]),  64'h0);
      check({tag, ".mem_sel"},   64'(bus.mem_sel),   64'h0);
      check({tag, ".mem_rw"},    64'(bus.mem_rw),    64'h0);
      check({tag, ".mem_addr"},  64'(bus.mem_addr),  64'h0);
      check({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'h0);
      check({tag, ".busy"},      64'(bus.busy),      64'h0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.req       = '0;
      bus.rw        = '0;
      bus.addr      = '0;
      bus.wdata     = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;

      // Reset state
      #2;
      check_all_zero("reset");
      step();
      rst_n = 1'b1;
      step();

      // 1: port 0 read, ready on the second ACCESS cycle
      bus.req[0]  = 1'b1;
      bus.rw[0]   = 1'b1;
      bus.addr[0] = 32'h10;
      step();
      check("t1.gnt",      64'(bus.gnt),      64'h1);
      check("t1.mem_sel",  64'(bus.mem_sel),  64'h1);
      check("t1.mem_addr", 64'(bus.mem_addr), 64'h10);
      check("t1.mem_rw",   64'(bus.mem_rw),   64'h1);
      check("t1.busy",     64'(bus.busy),     64'h1);
      step();
      check("t1.wait_done", 64'(bus.done), 64'h0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      step();
      check("t1.done",    64'(bus.done),     64'h1);
      check("t1.err",     64'(bus.err),      64'h0);
      check("t1.rdata0",  64'(bus.rdata[0]), 64'hDEADBEEF);
      check("t1.sel_off", 64'(bus.mem_sel),  64'h0);
      check("t1.gnt_off", 64'(bus.gnt),      64'h0);
      bus.req[0]    = 1'b0;
      bus.mem_ready = 1'b0;
      step();
      check("t1.done_pulse", 64'(bus.done), 64'h0);
      check("t1.idle",       64'(bus.busy), 64'h0);

      // 2: both requesting from reset, memory always ready -> 0,1,0,1
      rst_n = 1'b0;
      #1;
      bus.req       = 2'b11;
      bus.rw        = 2'b11;
      bus.addr[0]   = 32'hA0;
      bus.addr[1]   = 32'hB0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hCAFEF00D;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("t2.gnt%0d", i),  64'(bus.gnt),  (i % 2 == 0) ? 64'h1 : 64'h2);
         check($sformatf("t2.addr%0d", i), 64'(bus.mem_addr), (i % 2 == 0) ? 64'hA0 : 64'hB0);
         step();
         check($sformatf("t2.done%0d", i), 64'(bus.done), (i % 2 == 0) ? 64'h1 : 64'h2);
         check($sformatf("t2.gnt_off%0d", i), 64'(bus.gnt), 64'h0);
         if (i == 3) begin
            bus.req       = 2'b00;
            bus.mem_ready = 1'b0;
         end
         step();
         check($sformatf("t2.idle%0d", i), 64'(bus.busy), 64'h0);
      end

      // 3: port 1 write, address changed after grant
      bus.req[1]   = 1'b1;
      bus.rw[1]    = 1'b0;
      bus.addr[1]  = 32'h200;
      bus.wdata[1] = 32'h12345678;
      step();
      check("t3.gnt",       64'(bus.gnt),       64'h2);
      check("t3.mem_rw",    64'(bus.mem_rw),    64'h0);
      check("t3.mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
      bus.addr[1]  = 32'h300;
      bus.wdata[1] = 32'h0;
      step();
      check("t3.addr_held",  64'(bus.mem_addr),  64'h200);
      check("t3.wdata_held", 64'(bus.mem_wdata), 64'h12345678);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hFFFFFFFF;
      step();
      check("t3.done",   64'(bus.done),     64'h2);
      check("t3.rdata1", 64'(bus.rdata[1]), 64'hCAFEF00D);
      bus.req[1]    = 1'b0;
      bus.mem_ready = 1'b0;
      step();

      // 4: port 0 read never answered -> err0 after 15 ACCESS cycles
      bus.req[0]  = 1'b1;
      bus.rw[0]   = 1'b1;
      bus.addr[0] = 32'h40;
      step();
      check("t4.gnt", 64'(bus.gnt), 64'h1);
      for (int i = 1; i < 15; i++) step();
      check("t4.pre_err",  64'(bus.err),  64'h0);
      check("t4.pre_gnt",  64'(bus.gnt),  64'h1);
      step();
      check("t4.err",     64'(bus.err),     64'h1);
      check("t4.no_done", 64'(bus.done),    64'h0);
      check("t4.sel_off", 64'(bus.mem_sel), 64'h0);
      bus.req[0]  = 1'b0;
      bus.req[1]  = 1'b1;
      bus.rw[1]   = 1'b1;
      bus.addr[1] = 32'h44;
      step();
      check("t4.err_pulse", 64'(bus.err), 64'h0);
      step();
      check("t4.gnt1",  64'(bus.gnt),      64'h2);
      check("t4.addr1", 64'(bus.mem_addr), 64'h44);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0BADF00D;
      step();
      check("t4.done1", 64'(bus.done), 64'h2);
      bus.req[1]    = 1'b0;
      bus.mem_ready = 1'b0;
      step();

      // 5: ready arrives on the timeout edge -> done wins
      bus.req[0]    = 1'b1;
      bus.addr[0]   = 32'h50;
      bus.mem_rdata = 32'h5555AAAA;
      step();
      check("t5.gnt", 64'(bus.gnt), 64'h1);
      for (int i = 1; i < 15; i++) step();
      bus.mem_ready = 1'b1;
      step();
      check("t5.done",   64'(bus.done),     64'h1);
      check("t5.no_err", 64'(bus.err),      64'h0);
      check("t5.rdata0", 64'(bus.rdata[0]), 64'h5555AAAA);
      bus.req[0]    = 1'b0;
      bus.mem_ready = 1'b0;
      step();

      // 6: async reset mid-ACCESS, then port 0 wins first contention
      bus.req[0]  = 1'b1;
      bus.addr[0] = 32'h80;
      step();
      check("t6.gnt", 64'(bus.gnt), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6.async");
      bus.req = 2'b11;
      step();
      check("t6.rst_done", 64'(bus.done), 64'h0);
      check("t6.rst_err",  64'(bus.err),  64'h0);
      rst_n = 1'b1;
      step();
      check("t6.gnt_after", 64'(bus.gnt),      64'h1);
      check("t6.addr",      64'(bus.mem_addr), 64'h80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
